// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TAG  = 2'd1,
        DATA = 2'd2,
        TERM = 2'd3
    } arb_state_t;

    localparam logic [7:0] TAG_BASE          = 8'h41;
    localparam logic [7:0] TERM_CHAR_DEFAULT = 8'h0a;
    localparam logic       MODE_HEX          = 1'b0;
    localparam logic       MODE_BYTE         = 1'b1;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping.
module uart_rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest candidate down so the nearest one after ptr wins.
    always_comb begin
        idx  = ptr;
        any  = 1'b0;
        cand = '0;
        for (int off = NREQ; off >= 1; off--) begin
            cand = IDX_W'((32'(ptr) + 32'(off)) % 32'(NREQ));
            if (req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_grant
            assign grant[gi] = any && (idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/uart_tx_arbiter.sv
// Grants one shared uartsender to a requester for a whole record, with optional
// tag/terminator framing and forced release of a stalled owner.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int         NREQ      = 4,
    parameter bit         TAG_EN    = 1'b1,
    parameter bit         TERM_EN   = 1'b1,
    parameter logic [7:0] TERM_CHAR = TERM_CHAR_DEFAULT,
    parameter int         TIMEOUT   = 1024,
    parameter int         TO_LEN    = 11
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [NREQ-1:0]    REQ_VALID,
    input  logic [32*NREQ-1:0] REQ_DATA,
    input  logic [NREQ-1:0]    REQ_MODE,
    input  logic [NREQ-1:0]    REQ_LAST,
    output logic [NREQ-1:0]    REQ_ACK,
    output logic [NREQ-1:0]    GRANT,
    output logic [31:0]        TX_DATA,
    output logic               TX_MODE,
    output logic               TX_WE,
    input  logic               TX_READY,
    output logic               BUSY,
    output logic               TIMEOUT_ERR
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t       state_reg, state_next;
    logic [IDX_W-1:0] owner_reg, owner_next;
    logic [IDX_W-1:0] ptr_reg, ptr_next;
    logic [NREQ-1:0]  grant_reg, grant_next;
    logic [TO_LEN-1:0] cnt_reg, cnt_next;
    logic             timeout_err_reg, timeout_err_next;
    logic             issue_cond;
    logic             owner_valid;
    logic [NREQ-1:0]  pick_grant;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic [31:0]      req_word [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_word
            assign req_word[gi] = REQ_DATA[32*gi +: 32];
        end
    endgenerate

    uart_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (REQ_VALID),
        .ptr   (ptr_reg),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign owner_valid = REQ_VALID[owner_reg];
    assign TX_WE       = issue_cond & TX_READY;
    assign REQ_ACK     = (state_reg == DATA && TX_WE) ? grant_reg : '0;
    assign GRANT       = grant_reg;
    assign BUSY        = (state_reg != IDLE);
    assign TIMEOUT_ERR = timeout_err_reg;

    always_comb begin
        issue_cond = 1'b0;
        TX_DATA    = '0;
        TX_MODE    = MODE_HEX;
        case (state_reg)
            TAG: begin
                issue_cond = 1'b1;
                TX_MODE    = MODE_BYTE;
                TX_DATA    = {24'h0, TAG_BASE + 8'(owner_reg)};
            end
            DATA: begin
                issue_cond = owner_valid;
                TX_MODE    = REQ_MODE[owner_reg];
                TX_DATA    = req_word[owner_reg];
            end
            TERM: begin
                issue_cond = 1'b1;
                TX_MODE    = MODE_BYTE;
                TX_DATA    = {24'h0, TERM_CHAR};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next       = state_reg;
        owner_next       = owner_reg;
        ptr_next         = ptr_reg;
        grant_next       = grant_reg;
        cnt_next         = '0;
        timeout_err_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pick_any) begin
                    owner_next = pick_idx;
                    ptr_next   = pick_idx;
                    grant_next = pick_grant;
                    state_next = TAG_EN ? TAG : DATA;
                end
            end
            TAG: begin
                if (TX_WE) state_next = DATA;
            end
            DATA: begin
                if (TX_WE) begin
                    if (REQ_LAST[owner_reg]) begin
                        if (TERM_EN) begin
                            state_next = TERM;
                        end else begin
                            state_next = IDLE;
                            grant_next = '0;
                        end
                    end
                end else if (TIMEOUT > 0 && !owner_valid) begin
                    // Only an absent owner counts; a READY stall with VALID high never does.
                    if (cnt_reg == TO_LEN'(TIMEOUT - 1)) begin
                        state_next       = IDLE;
                        grant_next       = '0;
                        timeout_err_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + TO_LEN'(1);
                    end
                end
            end
            TERM: begin
                if (TX_WE) begin
                    state_next = IDLE;
                    grant_next = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_reg       <= IDLE;
            owner_reg       <= '0;
            ptr_reg         <= IDX_W'(NREQ - 1);
            grant_reg       <= '0;
            cnt_reg         <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            owner_reg       <= owner_next;
            ptr_reg         <= ptr_next;
            grant_reg       <= grant_next;
            cnt_reg         <= cnt_next;
            timeout_err_reg <= timeout_err_next;
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uartsender instance between NREQ independent requesters, such as measurement channels and a status/debug source. It grants the transmitter to one requester for a whole record, a sequence of words ending with LAST, so records never interleave on TXD. Grants are round-robin between records. It can add a channel tag character before each record and a terminator character after it. It also releases a stalled owner after a timeout.

Parameters:
NREQ, 4, number of requesters (2..8).
TAG_EN, 1, when 1, send character 8'h41+index ('A','B',...) in byte mode before each record.
TERM_EN, 1, when 1, send TERM_CHAR in byte mode after the LAST word of each record.
TERM_CHAR, 8'h0a, terminator byte.
TIMEOUT, 1024, idle cycles tolerated mid-record before forced release; 0 disables the timeout.
TO_LEN, 11, width of the timeout counter; must hold TIMEOUT.

Ports:
CLK  in  1  clock
RST_N  in  1  synchronous active-low reset
REQ_VALID  in  NREQ  per-requester word valid; held with data until ACK
REQ_DATA  in  32*NREQ  requester i word at [32i+31:32i]
REQ_MODE  in  NREQ  per-word mode (0 = 8 hex chars, 1 = raw byte DATA[7:0])
REQ_LAST  in  NREQ  word is the final word of its record
REQ_ACK  out  NREQ  one-cycle pulse when requester's word is accepted by transmitter
GRANT  out  NREQ  one-hot current owner; 0 when idle
TX_DATA  out  32  to uartsender DATA
TX_MODE  out  1  to uartsender MODE
TX_WE  out  1  to uartsender WE
TX_READY  in  1  from uartsender READY
BUSY  out  1  high in any state other than IDLE
TIMEOUT_ERR  out  1  one-cycle pulse on forced release

Behaviour:
- Reset (RST_N=0 at a clock edge), in all states including mid-record:
  - state goes to IDLE.
  - GRANT, REQ_ACK, TX_WE, BUSY and TIMEOUT_ERR go to 0.
  - TX_DATA and TX_MODE go to 0.
  - The round-robin pointer goes to NREQ-1, so requester 0 has top priority after reset.
  - The timeout counter goes to 0.
- Transfer rule:
  - TX_WE = issue_cond & TX_READY, combinational. Never assert WE while READY=0.
  - A word transfers in the cycle TX_WE=1. In the same cycle, REQ_ACK[owner]=1 if the word came from the requester.
- States:
  - IDLE:
    - If any REQ_VALID is set, pick the first set bit at or after ptr+1, wrapping modulo NREQ.
    - Latch the pick as owner, set ptr=owner, set GRANT next cycle.
    - Go to TAG if TAG_EN=1, else DATA.
    - The pick takes 1 cycle, so the first TX_WE comes at the earliest 1 cycle after VALID is seen in IDLE.
  - TAG:
    - issue_cond=1, TX_MODE=1, TX_DATA={24'h0, 8'h41+owner}.
    - On transfer, go to DATA.
    - No ACK is generated.
  - DATA:
    - issue_cond=REQ_VALID[owner].
    - TX_DATA and TX_MODE pass through from the owner's inputs.
    - On transfer with REQ_LAST[owner]=1, go to TERM if TERM_EN=1, else IDLE.
    - On transfer without LAST, stay in DATA.
  - TERM:
    - issue_cond=1, TX_MODE=1, TX_DATA={24'h0, TERM_CHAR}.
    - On transfer, go to IDLE.
- Back-to-back records:
  - IDLE always spends exactly 1 cycle on arbitration.
  - The uartsender drops READY for at least 1 cycle after each accept, so throughput is limited by the uartsender and not by the arbiter.
- Timeout (TIMEOUT>0, DATA state only):
  - The counter increments each cycle REQ_VALID[owner]=0 and clears on VALID=1.
  - It also clears when leaving DATA.
  - TX_READY=0 stalls never count: counting requires VALID=0.
  - When the counter reaches TIMEOUT-1 with VALID still 0:
    - go to IDLE and pulse TIMEOUT_ERR.
    - send no terminator; the truncated record is visible to the host through the missing terminator.
- Non-owner requesters: their REQ_ACK stays 0 and their VALID is ignored until arbitrated.
- LAST and MODE are sampled only on a transferring cycle. A requester changing DATA or VALID before ACK is a protocol violation; no checking is done.
- GRANT stays stable for the whole record, including the TAG and TERM phases.
- TX_DATA and TX_MODE are don't-care when TX_WE=0. For determinism, drive 0 in IDLE.

Decomposition:
- Shared package uart_pkg:
  - state encoding: IDLE, TAG, DATA, TERM (2-bit).
  - TAG_BASE=8'h41.
  - default TERM_CHAR.
  - mode constants MODE_HEX=1'b0, MODE_BYTE=1'b1.
- One sub-module, uart_rr_pick, is natural.
  - Combinational round-robin picker.
  - Inputs: req[NREQ-1:0] and ptr.
  - Outputs: one-hot grant, index, any.
  - It is reusable by other arbiters in the design.

Test Plan:
1. TAG_EN=1, TERM_EN=1; req0 sends one word 32'hdeadbeef with LAST, TX_READY=1 -> TX_WE sequence (mode,data) is (1,0x41), (0,0xdeadbeef), (1,0x0a); REQ_ACK[0] pulses once; GRANT=0001 throughout; BUSY falls after TERM.
2. req0 and req1 both assert in the same cycle, 2-word records each -> req0's tag, both words and terminator complete before req1's 'B' tag; there is no interleaving; GRANT goes 0001 then 0010.
3. All 4 requesters hold single-word records continuously -> grant order is 0,1,2,3,0,1; each REQ_ACK pulses once per grant.
4. TIMEOUT=16; req2 sends one non-LAST word then drops VALID -> TIMEOUT_ERR pulses exactly 16 cycles after the drop; no 0x0a is sent; the next pending requester (3) is granted.
5. Hold TX_READY=0 for 100 cycles with req1 valid in DATA -> TX_WE=0, REQ_ACK=0 and TIMEOUT_ERR=0 throughout; on TX_READY=1 the word transfers in that same cycle.
6. Assert RST_N=0 for 1 cycle while req3 is mid-record -> next cycle GRANT=0, BUSY=0, TX_WE=0; with all requesting afterwards, req0 is granted first.
